// File: rtl/iq_demod_pkg.sv
// Shared types and the fs/4 mixing rule for the IQ demodulator/decimator.
`timescale 1ns/1ps
package iq_demod_pkg;

  typedef enum logic [1:0] {PH_0 = 2'd0, PH_1 = 2'd1, PH_2 = 2'd2, PH_3 = 2'd3} phase_t;

  localparam logic SB_UPPER     = 1'b0;
  localparam logic SB_LOWER     = 1'b1;
  localparam int   MAX_DEC_LOG2 = 4;

  typedef struct packed {
    logic signed [31:0] i_m;
    logic signed [31:0] q_m;
  } mix_pair_t;

  // cos = +1,0,-1,0 and sin = 0,+s,0,-s, so every product is a pass, a negate or a zero.
  function automatic mix_pair_t mix_fs4(input phase_t ph, input logic sb,
                                        input logic signed [31:0] i,
                                        input logic signed [31:0] q);
    mix_pair_t r;
    logic signed [31:0] i_s;
    logic signed [31:0] q_s;
    i_s = (sb == SB_LOWER) ? -i : i;
    q_s = (sb == SB_LOWER) ? -q : q;
    case (ph)
      PH_0:    begin r.i_m = i;    r.q_m = q;    end
      PH_1:    begin r.i_m = -q_s; r.q_m = i_s;  end
      PH_2:    begin r.i_m = -i;   r.q_m = -q;   end
      default: begin r.i_m = q_s;  r.q_m = -i_s; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/iq_mixer_fs4.sv
// Quarter-rate phase counter and registered fs/4 mixer (pipeline stage 1).
`timescale 1ns/1ps
module iq_mixer_fs4
  import iq_demod_pkg::*;
#(
  parameter int DATA_W = 5
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     adc_rdy,
  input  logic signed [DATA_W-1:0] i_if,
  input  logic signed [DATA_W-1:0] q_if,
  input  logic                     sideband,
  input  logic                     phase_sync,
  output logic signed [DATA_W:0]   i_m,
  output logic signed [DATA_W:0]   q_m,
  output logic                     mix_vld,
  output phase_t                   phase
);

  phase_t     cur_ph;
  phase_t     nxt_ph;
  logic [1:0] ph_inc;
  mix_pair_t  mix;
  logic       unused_mix_msbs;

  // A sync strobe makes the sample in the same cycle the phase-0 sample.
  always_comb begin
    cur_ph = phase_sync ? PH_0 : phase;
    ph_inc = cur_ph + 2'd1;
    nxt_ph = phase_t'(ph_inc);
    mix    = mix_fs4(cur_ph, sideband, 32'(i_if), 32'(q_if));
  end

  assign unused_mix_msbs = ^{mix.i_m[31:DATA_W+1], mix.q_m[31:DATA_W+1]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase   <= PH_0;
      mix_vld <= 1'b0;
      i_m     <= '0;
      q_m     <= '0;
    end else if (adc_rdy) begin
      phase   <= nxt_ph;
      mix_vld <= 1'b1;
      i_m     <= mix.i_m[DATA_W:0];
      q_m     <= mix.q_m[DATA_W:0];
    end else begin
      phase   <= cur_ph;
      mix_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/iq_demod_decim.sv
// fs/4 IQ baseband demodulator followed by a 2^DEC_LOG2 integrate-and-dump decimator.
`timescale 1ns/1ps
module iq_demod_decim
  import iq_demod_pkg::*;
#(
  parameter  int DATA_W   = 5,
  parameter  int DEC_LOG2 = 0,
  localparam int OUT_W    = DATA_W + 1 + DEC_LOG2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     ADC_rdy,
  input  logic signed [DATA_W-1:0] I_IF,
  input  logic signed [DATA_W-1:0] Q_IF,
  input  logic                     sideband,
  input  logic                     phase_sync,
  output logic signed [OUT_W-1:0]  I_BB,
  output logic signed [OUT_W-1:0]  Q_BB,
  output logic                     demod_rdy,
  output logic [1:0]               phase
);

  // Handshake: ADC_rdy and demod_rdy are single-cycle strobes with no back-pressure;
  // I_IF/Q_IF are valid only while ADC_rdy is high, I_BB/Q_BB change only with demod_rdy.

  localparam int                CNT_W    = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << DEC_LOG2) - 1);

  if (DEC_LOG2 < 0 || DEC_LOG2 > MAX_DEC_LOG2) begin : g_bad_dec_log2
    $error("iq_demod_decim: DEC_LOG2=%0d outside 0..%0d", DEC_LOG2, MAX_DEC_LOG2);
  end

  logic signed [DATA_W:0]  i_m;
  logic signed [DATA_W:0]  q_m;
  logic                    mix_vld;
  phase_t                  mix_phase;
  logic signed [OUT_W-1:0] acc_i;
  logic signed [OUT_W-1:0] acc_q;
  logic signed [OUT_W-1:0] sum_i;
  logic signed [OUT_W-1:0] sum_q;
  logic [CNT_W-1:0]        dec_cnt;

  iq_mixer_fs4 #(.DATA_W(DATA_W)) u_mixer (
    .clk        (clk),
    .resetn     (resetn),
    .adc_rdy    (ADC_rdy),
    .i_if       (I_IF),
    .q_if       (Q_IF),
    .sideband   (sideband),
    .phase_sync (phase_sync),
    .i_m        (i_m),
    .q_m        (q_m),
    .mix_vld    (mix_vld),
    .phase      (mix_phase)
  );

  assign phase = mix_phase;
  assign sum_i = acc_i + OUT_W'(i_m);
  assign sum_q = acc_q + OUT_W'(q_m);

  // A sync drops the stage-1 sample waiting here so no partial group is ever dumped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_i     <= '0;
      acc_q     <= '0;
      dec_cnt   <= '0;
      I_BB      <= '0;
      Q_BB      <= '0;
      demod_rdy <= 1'b0;
    end else if (phase_sync) begin
      acc_i     <= '0;
      acc_q     <= '0;
      dec_cnt   <= '0;
      demod_rdy <= 1'b0;
    end else if (mix_vld) begin
      if (dec_cnt == CNT_LAST) begin
        I_BB      <= sum_i;
        Q_BB      <= sum_q;
        acc_i     <= '0;
        acc_q     <= '0;
        dec_cnt   <= '0;
        demod_rdy <= 1'b1;
      end else begin
        acc_i     <= sum_i;
        acc_q     <= sum_q;
        dec_cnt   <= dec_cnt + 1'b1;
        demod_rdy <= 1'b0;
      end
    end else begin
      demod_rdy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iq_demod_decim.sv
// Bench for iq_demod_decim: one instance without decimation, one decimating by 4.
`timescale 1ns/1ps
module tb_iq_demod_decim;

  typedef struct { int due; int i; int q; } exp_t;
  typedef struct { int cyc; int i; int q; } obs_t;

  logic              clk;
  logic              resetn;
  logic              ADC_rdy;
  logic signed [4:0] I_IF;
  logic signed [4:0] Q_IF;
  logic              sideband;
  logic              phase_sync;
  logic signed [5:0] i_bb0, q_bb0;
  logic signed [7:0] i_bb2, q_bb2;
  logic              rdy0, rdy2;
  logic [1:0]        ph0, ph2;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   gsz[2] = '{1, 4};
  int   cos_t[4] = '{1, 0, -1, 0};
  int   sin_t[4] = '{0, 1, 0, -1};
  int   m_phase, pend_i, pend_q, pend_cyc;
  bit   pend_v;
  int   g_si[2], g_sq[2], g_n[2], last_i[2], last_q[2];
  exp_t exp_q[2][$];
  obs_t obs_q[2][$];
  int   s_cyc[4];
  int   ai[4] = '{5, -3, -5, 3};
  int   aq[4] = '{3, 5, -3, -5};

  iq_demod_decim #(.DATA_W(5), .DEC_LOG2(0)) dut0 (
    .clk(clk), .resetn(resetn), .ADC_rdy(ADC_rdy), .I_IF(I_IF), .Q_IF(Q_IF),
    .sideband(sideband), .phase_sync(phase_sync),
    .I_BB(i_bb0), .Q_BB(q_bb0), .demod_rdy(rdy0), .phase(ph0)
  );

  iq_demod_decim #(.DATA_W(5), .DEC_LOG2(2)) dut2 (
    .clk(clk), .resetn(resetn), .ADC_rdy(ADC_rdy), .I_IF(I_IF), .Q_IF(Q_IF),
    .sideband(sideband), .phase_sync(phase_sync),
    .I_BB(i_bb2), .Q_BB(q_bb2), .demod_rdy(rdy2), .phase(ph2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500us");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A strobe joins its group unless a sync arrives in the very next cycle; a group of
  // gsz samples yields its sum two cycles after its last strobe.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_phase = 0;
      pend_v  = 0;
      for (int d = 0; d < 2; d++) begin
        g_si[d] = 0; g_sq[d] = 0; g_n[d] = 0; last_i[d] = 0; last_q[d] = 0;
        exp_q[d].delete();
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (phase_sync) begin
          g_si[d] = 0; g_sq[d] = 0; g_n[d] = 0;
        end else if (pend_v) begin
          g_si[d] += pend_i; g_sq[d] += pend_q; g_n[d]++;
          if (g_n[d] == gsz[d]) begin
            exp_q[d].push_back('{pend_cyc + 2, g_si[d], g_sq[d]});
            g_si[d] = 0; g_sq[d] = 0; g_n[d] = 0;
          end
        end
      end
      pend_v = 0;
      if (ADC_rdy) begin
        int ph, c, s;
        ph = phase_sync ? 0 : m_phase;
        c  = cos_t[ph];
        s  = sideband ? -sin_t[ph] : sin_t[ph];
        pend_i   = int'(I_IF) * c - int'(Q_IF) * s;
        pend_q   = int'(I_IF) * s + int'(Q_IF) * c;
        pend_v   = 1;
        pend_cyc = cyc;
        m_phase  = (ph + 1) % 4;
      end else if (phase_sync) begin
        m_phase = 0;
      end
      cyc++;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic cmp_dut(input int d, input bit rdy, input int bi, input int bq, input int ph);
    chk($sformatf("d%0d_phase", d), ph, m_phase);
    while (exp_q[d].size() > 0 && exp_q[d][0].due < cyc) exp_q[d].pop_front();
    if (exp_q[d].size() > 0 && exp_q[d][0].due == cyc) begin
      chk($sformatf("d%0d_demod_rdy", d), int'(rdy), 1);
      last_i[d] = exp_q[d][0].i;
      last_q[d] = exp_q[d][0].q;
      exp_q[d].pop_front();
    end else begin
      chk($sformatf("d%0d_demod_rdy", d), int'(rdy), 0);
    end
    chk($sformatf("d%0d_I_BB", d), bi, last_i[d]);
    chk($sformatf("d%0d_Q_BB", d), bq, last_q[d]);
    if (rdy) obs_q[d].push_back('{cyc, bi, bq});
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      cmp_dut(0, rdy0, int'(i_bb0), int'(q_bb0), int'(ph0));
      cmp_dut(1, rdy2, int'(i_bb2), int'(q_bb2), int'(ph2));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int i, input int q, input bit sb, input bit sync);
    I_IF = 5'(i); Q_IF = 5'(q); sideband = sb; phase_sync = sync; ADC_rdy = 1'b1;
    idle(1);
    ADC_rdy = 1'b0; phase_sync = 1'b0;
  endtask

  task automatic sync_only();
    phase_sync = 1'b1;
    idle(1);
    phase_sync = 1'b0;
  endtask

  task automatic group4(input int gap_max);
    strobe(4, 0, 0, 0);  idle($urandom_range(0, gap_max));
    strobe(0, -4, 0, 0); idle($urandom_range(0, gap_max));
    strobe(-4, 0, 0, 0); idle($urandom_range(0, gap_max));
    strobe(0, 4, 0, 0);  idle($urandom_range(0, gap_max));
  endtask

  task automatic clear_obs();
    obs_q[0].delete();
    obs_q[1].delete();
  endtask

  task automatic chk_obs(input string nm, input int d, input int k, input int ei, input int eq);
    if (k < obs_q[d].size()) begin
      chk({nm, "_I"}, obs_q[d][k].i, ei);
      chk({nm, "_Q"}, obs_q[d][k].q, eq);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    resetn = 1'b0; ADC_rdy = 1'b0; I_IF = '0; Q_IF = '0; sideband = 1'b0; phase_sync = 1'b0;
    idle(3);
    chk("rst_I_BB", int'(i_bb0), 0);
    chk("rst_Q_BB", int'(q_bb2), 0);
    chk("rst_rdy", int'(rdy0 | rdy2), 0);
    chk("rst_phase", int'(ph0), 0);
    resetn = 1'b1;
    idle(1);

    // Upper sideband, I=5 Q=3 at phases 0..3.
    clear_obs();
    for (int k = 0; k < 4; k++) begin
      s_cyc[k] = cyc;
      strobe(5, 3, 0, 0);
      chk("a_phase", int'(ph0), (k + 1) % 4);
    end
    idle(3);
    chk("a_count", obs_q[0].size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk_obs("a_bb", 0, k, ai[k], aq[k]);
      if (k < obs_q[0].size()) chk("a_latency", obs_q[0][k].cyc - s_cyc[k], 2);
    end

    // Most negative input at phase 2 negates exactly.
    clear_obs();
    strobe(0, 0, 0, 0); strobe(0, 0, 0, 0); strobe(-16, -16, 0, 0); strobe(0, 0, 0, 0);
    idle(3);
    chk("b_count", obs_q[0].size(), 4);
    chk_obs("b_neg", 0, 2, 16, 16);
    chk_obs("b_dec4", 1, 0, 16, 16);

    // Lower sideband at phases 1 and 3.
    clear_obs();
    strobe(0, 0, 1, 0); strobe(5, 3, 1, 0); strobe(0, 0, 1, 0); strobe(5, 3, 1, 0);
    idle(3);
    chk_obs("c_ph1", 0, 1, 3, -5);
    chk_obs("c_ph3", 0, 3, -3, 5);

    // Decimate-by-4 groups with random strobe gaps.
    sync_only();
    clear_obs();
    for (int g = 0; g < 3; g++) group4(3);
    idle(3);
    chk("d_groups", obs_q[1].size(), 3);
    for (int k = 0; k < 3; k++) chk_obs("d_sum", 1, k, 16, 0);

    // Sync after two strobes, one cycle after the second: partial group and pending sample lost.
    clear_obs();
    strobe(4, 0, 0, 0); strobe(0, -4, 0, 0);
    sync_only();
    idle(3);
    chk("e_partial", obs_q[1].size(), 0);
    chk("e_pending", obs_q[0].size(), 1);
    clear_obs();
    strobe(4, 0, 0, 0);
    chk("e_phase", int'(ph2), 1);
    strobe(0, -4, 0, 0); strobe(-4, 0, 0, 0); strobe(0, 4, 0, 0);
    idle(3);
    chk("e_groups", obs_q[1].size(), 1);
    chk_obs("e_sum", 1, 0, 16, 0);

    // Sync coincident with a strobe: that sample opens the new group.
    clear_obs();
    strobe(4, 0, 0, 0); strobe(0, -4, 0, 0);
    strobe(4, 0, 0, 1);
    chk("f_phase", int'(ph2), 1);
    strobe(0, -4, 0, 0); strobe(-4, 0, 0, 0); strobe(0, 4, 0, 0);
    idle(3);
    chk("f_groups", obs_q[1].size(), 1);
    chk_obs("f_sum", 1, 0, 16, 0);
    chk("f_dec1_count", obs_q[0].size(), 5);
    chk("f_outstanding0", exp_q[0].size(), 0);
    chk("f_outstanding2", exp_q[1].size(), 0);

    // Asynchronous reset in the middle of a group.
    clear_obs();
    strobe(4, 0, 0, 0); strobe(0, -4, 0, 0);
    #2;
    resetn = 1'b0;
    #1;
    chk("g_rst_I_BB0", int'(i_bb0), 0);
    chk("g_rst_Q_BB2", int'(q_bb2), 0);
    chk("g_rst_I_BB2", int'(i_bb2), 0);
    chk("g_rst_rdy0", int'(rdy0), 0);
    chk("g_rst_phase", int'(ph2), 0);
    idle(1);
    strobe(3, 3, 0, 0); strobe(3, 3, 0, 0);
    chk("g_rst_phase_hold", int'(ph0), 0);
    chk("g_rst_rdy_hold", int'(rdy0 | rdy2), 0);
    resetn = 1'b1;
    idle(4);
    chk("g_no_dump", obs_q[1].size(), 0);
    chk("g_phase_after", int'(ph2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
